// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, frame constants and counter sizing for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
  localparam int DATA_BITS = 8;
  localparam logic TX_IDLE_LEVEL = 1'b1;
  function automatic int cnt_width(input int clks);
    return (clks < 3) ? 1 : $clog2(clks);
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period counter with sync clear and a one-cycle end-of-bit tick
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);
  localparam int W = cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign bit_tick = ~clear & (cnt == LAST);
  // count 0..CLKS_PER_BIT-1 and wrap; held at zero while cleared so a frame starts on a full bit
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (clear | bit_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: one-byte buffered UART transmitter with optional parity and 1/2 stop bits
module ascii_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042,
  parameter int STOP_BITS = 1,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  state_t state, state_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, hold, hold_n;
  logic full, full_n, tx_n, done_n, load, tick, par;
  assign par = ^shift ^ 1'(PARITY_ODD);
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .reset(reset),
    .clear(state == IDLE),
    .bit_tick(tick)
  );
  // all outputs are registered; reset forces the line high immediately
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      shift      <= '0;
      hold       <= '0;
      full       <= 1'b0;
      tx         <= TX_IDLE_LEVEL;
      char_ready <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      shift      <= shift_n;
      hold       <= hold_n;
      full       <= full_n;
      tx         <= tx_n;
      char_ready <= ~full_n;
      busy       <= (state_n != IDLE) | full_n;
      frame_done <= done_n;
    end
  // next-state: accept into the holding buffer, walk the frame, reload from holding at frame start
  always_comb begin
    state_n = state;
    idx_n   = idx;
    shift_n = shift;
    hold_n  = hold;
    full_n  = full;
    tx_n    = tx;
    done_n  = 1'b0;
    load    = 1'b0;
    if (char_valid && char_ready) begin
      hold_n = char_in;
      full_n = 1'b1;
    end
    case (state)
      IDLE: load = full;
      START:
        if (tick) begin
          state_n = DATA;
          tx_n    = shift[0];
        end
      DATA:
        if (tick) begin
          idx_n   = (idx == LAST_DATA) ? 3'd0 : idx + 3'd1;
          state_n = (idx != LAST_DATA) ? DATA : (PARITY_EN != 0) ? PARITY : STOP;
          tx_n    = (idx != LAST_DATA) ? shift[idx + 3'd1] : (PARITY_EN != 0) ? par : TX_IDLE_LEVEL;
        end
      PARITY:
        if (tick) begin
          state_n = STOP;
          tx_n    = TX_IDLE_LEVEL;
        end
      STOP:
        if (tick) begin
          idx_n = (idx == LAST_STOP) ? 3'd0 : idx + 3'd1;
          if (idx == LAST_STOP) begin
            done_n  = 1'b1;
            state_n = IDLE;
            load    = full;
          end
        end
      default: state_n = IDLE;
    endcase
    if (load) begin
      shift_n = hold;
      full_n  = 1'b0;
      tx_n    = 1'b0;
      state_n = START;
    end
  end
endmodule

// File: tb/tb_ascii_uart_tx.sv
// tb_ascii_uart_tx: four transmitter configurations checked by per-channel serial scoreboards
module tb_ascii_uart_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] char_in[4];
  logic char_valid[4], char_ready[4], tx[4], busy[4], frame_done[4];
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string nm, input int act, input int req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, req);
    end
  endtask

  function automatic logic [15:0] frame_bits(input logic [7:0] b, input int pe, input int po);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
    if (pe != 0) f[9] = 1'(($countones(b) + po) % 2);
    return f;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_ch
    localparam int N  = (g == 3) ? 2 : 4;
    localparam int PE = (g == 1 || g == 2) ? 1 : 0;
    localparam int PO = (g == 2) ? 1 : 0;
    localparam int SB = (g == 1 || g == 2) ? 2 : 1;
    localparam int L  = 9 + PE + SB;
    logic [7:0] q[$];
    int frames = 0, contig = 0, fd_cnt = 0;
    bit abort_f = 1'b0;

    ascii_uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(SB), .PARITY_EN(PE), .PARITY_ODD(PO)) dut (
      .clk(clk),
      .reset(reset),
      .char_in(char_in[g]),
      .char_valid(char_valid[g]),
      .char_ready(char_ready[g]),
      .tx(tx[g]),
      .busy(busy[g]),
      .frame_done(frame_done[g])
    );

    always @(posedge clk)
      if (!reset && char_valid[g] && char_ready[g]) q.push_back(char_in[g]);

    always @(posedge reset) begin
      q.delete();
      abort_f = 1'b1;
    end

    always @(negedge clk)
      if (frame_done[g]) fd_cnt++;

    initial begin : mon
      logic [15:0] fb;
      logic [7:0] b;
      int gap;
      bit pend;
      gap = 1;
      pend = 1'b0;
      forever begin
        @(negedge clk);
        if (pend && !abort_f) check(frame_done[g] == 1'b1, "frame_done_at_end", int'(frame_done[g]), 1);
        pend = 1'b0;
        if (reset || tx[g]) begin
          gap++;
          continue;
        end
        abort_f = 1'b0;
        if (gap == 0) contig++;
        b = 8'h00;
        if (q.size() == 0) check(1'b0, "unexpected_frame", g, -1);
        else b = q.pop_front();
        fb = frame_bits(b, PE, PO);
        for (int c = 0; c < L * N; c++) begin
          if (c > 0) @(negedge clk);
          if (abort_f) break;
          check(tx[g] == fb[c / N], "tx_bit", int'(tx[g]), int'(fb[c / N]));
          if (c > 0) check(frame_done[g] == 1'b0, "frame_done_early", int'(frame_done[g]), 0);
        end
        pend = !abort_f;
        if (!abort_f) frames++;
        gap = abort_f ? 1 : 0;
      end
    end
  end

  task automatic send(input int k, input logic [7:0] b);
    int t;
    @(negedge clk);
    char_valid[k] = 1'b1;
    char_in[k] = b;
    for (t = 0; t < 1000 && !char_ready[k]; t++) @(negedge clk);
    if (t == 1000) check(1'b0, "accept_timeout", k, 1);
    @(posedge clk);
  endtask

  task automatic drop(input int k);
    @(negedge clk);
    char_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int t;
    for (t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (!busy[k] && tx[k]) break;
    end
    if (t == 2000) check(1'b0, "idle_timeout", k, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int f0, c0, d0;
    for (int k = 0; k < 4; k++) begin
      char_in[k] = 8'h00;
      char_valid[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check(tx[0] && char_ready[0] && !busy[0], "idle_outputs", {tx[0], char_ready[0], busy[0]}, 3'b110);
    end
    check(g_ch[0].fd_cnt == 0, "idle_frame_done", g_ch[0].fd_cnt, 0);

    f0 = g_ch[0].frames;
    d0 = g_ch[0].fd_cnt;
    send(0, 8'h47);
    drop(0);
    check(tx[0] == 1'b1, "tx_before_fall", int'(tx[0]), 1);
    check(char_ready[0] == 1'b0, "ready_after_accept", int'(char_ready[0]), 0);
    check(busy[0] == 1'b1, "busy_after_accept", int'(busy[0]), 1);
    @(negedge clk);
    check(tx[0] == 1'b0, "tx_fall", int'(tx[0]), 0);
    check(char_ready[0] == 1'b1, "ready_rise", int'(char_ready[0]), 1);
    wait_idle(0);
    check(g_ch[0].frames - f0 == 1, "single_frames", g_ch[0].frames - f0, 1);
    check(g_ch[0].fd_cnt - d0 == 1, "single_done", g_ch[0].fd_cnt - d0, 1);

    f0 = g_ch[0].frames;
    c0 = g_ch[0].contig;
    d0 = g_ch[0].fd_cnt;
    send(0, 8'h47);
    send(0, 8'h75);
    send(0, 8'h61);
    drop(0);
    wait_idle(0);
    check(g_ch[0].frames - f0 == 3, "b2b_frames", g_ch[0].frames - f0, 3);
    check(g_ch[0].contig - c0 == 2, "b2b_contiguous", g_ch[0].contig - c0, 2);
    check(g_ch[0].fd_cnt - d0 == 3, "b2b_done", g_ch[0].fd_cnt - d0, 3);

    f0 = g_ch[1].frames + g_ch[2].frames;
    send(1, 8'h51);
    drop(1);
    send(2, 8'h51);
    drop(2);
    wait_idle(1);
    wait_idle(2);
    check(g_ch[1].frames + g_ch[2].frames - f0 == 2, "parity_frames", g_ch[1].frames + g_ch[2].frames - f0, 2);
    for (int i = 0; i < 4; i++) begin
      send(1 + i % 2, 8'($urandom));
      drop(1 + i % 2);
      wait_idle(1 + i % 2);
    end
    check(g_ch[1].frames + g_ch[2].frames - f0 == 6, "parity_rand_frames", g_ch[1].frames + g_ch[2].frames - f0, 6);

    send(0, 8'h47);
    send(0, 8'h75);
    drop(0);
    repeat (15) @(posedge clk);
    #1;
    check(tx[0] == 1'b0, "tx_data_bit3", int'(tx[0]), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check(tx[0] == 1'b1, "reset_tx_async", int'(tx[0]), 1);
    check(char_ready[0] == 1'b1, "reset_ready", int'(char_ready[0]), 1);
    check(busy[0] == 1'b0, "reset_busy", int'(busy[0]), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    f0 = g_ch[0].frames;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check(tx[0] == 1'b1, "no_held_byte_sent", int'(tx[0]), 1);
    end
    send(0, 8'h41);
    drop(0);
    wait_idle(0);
    check(g_ch[0].frames - f0 == 1, "post_reset_frame", g_ch[0].frames - f0, 1);

    f0 = g_ch[3].frames;
    c0 = g_ch[3].contig;
    send(3, 8'hFF);
    send(3, 8'h00);
    drop(3);
    wait_idle(3);
    check(g_ch[3].frames - f0 == 2, "min_baud_frames", g_ch[3].frames - f0, 2);
    check(g_ch[3].contig - c0 == 1, "min_baud_contig", g_ch[3].contig - c0, 1);
    for (int i = 0; i < 5; i++) send(3, 8'($urandom));
    drop(3);
    wait_idle(3);
    check(g_ch[3].frames - f0 == 7, "min_baud_rand", g_ch[3].frames - f0, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ascii_uart_tx.md
Name: ascii_uart_tx

Overview:
- Downstream consumer of the ASCII character stream produced by the message-sequencer stage ("Guatemala" / "Quetzal" bytes).
- Accepts one 8-bit ASCII byte per valid/ready handshake and serialises it as an asynchronous UART frame on a single pin: start, 8 data bits LSB-first, optional parity, 1 or 2 stops.
- A one-entry holding buffer lets consecutive characters go out back-to-back with no idle gap.

Parameters:
- CLKS_PER_BIT, 1042, clock cycles per serial bit (10 MHz / 9600 baud); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_EN, 0, 1 inserts a parity bit after bit 7.
- PARITY_ODD, 0, with PARITY_EN=1: 0 selects even parity, 1 selects odd.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- char_in  input  8  ASCII byte from the sequencer stage.
- char_valid  input  1  char_in holds a byte to send.
- char_ready  output  1  holding buffer is empty; a byte is accepted on any edge where char_valid=1 and char_ready=1.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line or the holding buffer is full.
- frame_done  output  1  one-cycle pulse on the edge that ends the last stop bit.

Behaviour:
- Reset (async, immediate):
  - tx=1, char_ready=1, busy=0, frame_done=0.
  - FSM=IDLE, baud counter=0, bit index=0, holding buffer empty.
  - A frame in flight is aborted and the held byte is discarded; tx rises immediately, with no glitch low.
- Holding buffer:
  - char_ready is registered and equals "holding empty".
  - Accept edge: store char_in and set full. char_ready drops on that same edge.
  - char_in and char_valid are ignored while char_ready=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on the first edge where holding is full, copy holding to the shift register, clear full, set tx<=0, go to START. tx falls exactly 1 cycle after the accept edge.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0. The state or bit advances on the edge where counter=CLKS_PER_BIT-1.
  - START -> DATA: tx<=shift[0].
  - DATA: 8 bits, index 0..7, LSB first. After bit 7, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: tx = XOR of the 8 data bits, further XORed with PARITY_ODD.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At its end, pulse frame_done.
    - If holding is full: load it and go directly to START on that same edge (tx<=0). Zero idle cycles between frames.
    - Otherwise go to IDLE.
- Frame length = (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles.
- busy = (FSM != IDLE) | holding full; registered, with no combinational path from inputs.
- Simultaneous events:
  - A new accept can never coincide with a holding-to-shifter transfer, because char_ready=0 while holding is full.
  - The transfer clears full, and char_ready rises on the following edge.
- The byte value is transmitted unmodified; no ASCII range checking.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (3-bit encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4).
  - Constants DATA_BITS=8 and TX_IDLE_LEVEL=1.
  - Function for baud-counter width: clog2(CLKS_PER_BIT).
- One natural sub-module, uart_baud_gen:
  - Parameterised counter with sync clear (asserted on frame start) and a one-cycle bit_tick output.
  - Async active-high reset on the same clk/reset.
- The FSM, shifter and holding buffer stay in ascii_uart_tx.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset, then idle 50 cycles -> tx=1, char_ready=1, busy=0, frame_done never pulses.
- Send 0x47 ('G'), PARITY_EN=0, STOP_BITS=1 -> tx low 1 cycle after accept. Sampled mid-bit, the sequence is 0,1,1,1,0,0,0,1,0,1. frame_done pulses at cycle 40 after the fall. char_ready rises 1 cycle after accept.
- Hold char_valid high with 'G','u','a' -> the three frames are contiguous: exactly 120 cycles from the first tx fall to the last stop end, and no tx=1 cycle between a stop bit and the next start. Three frame_done pulses.
- PARITY_EN=1, PARITY_ODD=0, send 0x51 ('Q') -> parity bit=1. STOP_BITS=2, so the frame is 48 cycles. With PARITY_ODD=1, the parity bit=0.
- Assert reset for 1 cycle during data bit 3 of 0x47, with 'u' held in the buffer -> tx=1 asynchronously. 'u' is never transmitted, char_ready=1 after reset, and the next accepted byte produces a clean full frame.
- CLKS_PER_BIT=2 (minimum), send 0xFF then 0x00 -> each bit lasts exactly 2 cycles, and the total is 40 cycles back-to-back.
